mc_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the RV32I datapath: pc, imem/dmem port, decoder, regfile, immgen and alu.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states over a shared, handshaked memory port.
- Drives the PC, IR/MDR, regfile and ALU-operand select/enable signals.
- Counts retired instructions and traps sticky on illegal instructions, SYSTEM instructions or memory timeout.

---
 rtl/rv32_ctrl_pkg.sv | 69 ++++++
 rtl/mc_ctrl_fsm_if.sv | 11 +
 rtl/mc_ctrl_fsm_wait_timer.sv | 22 ++
 rtl/mc_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer: opcodes, FSM states,
// datapath mux selects, trap causes and small per-opcode select helpers.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP       = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] LOAD     = 7'h03;
  localparam logic [6:0] STORE    = 7'h23;
  localparam logic [6:0] BRANCH   = 7'h63;
  localparam logic [6:0] JAL      = 7'h6F;
  localparam logic [6:0] JALR     = 7'h67;
  localparam logic [6:0] LUI      = 7'h37;
  localparam logic [6:0] AUIPC    = 7'h17;
  localparam logic [6:0] MISC_MEM = 7'h0F;
  localparam logic [6:0] SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10} pc_src_t;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11} wb_sel_t;
  typedef enum logic [1:0] {A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} alu_a_t;
  typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_SYSTEM = 2'b10, TC_TIMEOUT = 2'b11} trap_cause_t;

  typedef struct packed {
    alu_a_t a_sel;
    logic   b_sel;
  } alu_ops_t;

  // Operand selects are held from EXEC through MEM/WB so the ALU result stays valid.
  function automatic alu_ops_t alu_ops(input logic [6:0] opc);
    alu_ops_t ops;
    ops.a_sel = A_RS1;
    ops.b_sel = 1'b0;
    case (opc)
      OP_IMM, LOAD, STORE, JAL, JALR: ops.b_sel = 1'b1;
      AUIPC: begin
        ops.a_sel = A_PC;
        ops.b_sel = 1'b1;
      end
      default: ;
    endcase
    return ops;
  endfunction

  function automatic wb_sel_t wb_sel_for(input logic [6:0] opc);
    case (opc)
      LOAD:      return WB_MDR;
      JAL, JALR: return WB_PC4;
      LUI:       return WB_IMM;
      default:   return WB_ALU;
    endcase
  endfunction

  function automatic pc_src_t wb_pc_src(input logic [6:0] opc);
    case (opc)
      JAL:     return PC_IMM;
      JALR:    return PC_ALU;
      default: return PC_PLUS4;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Shared instruction/data memory handshake between the sequencer (master) and memory (slave).
interface mc_ctrl_fsm_if;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [2:0] mem_size;
  logic       mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, mem_size, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, mem_size, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// Wait-cycle counter for a pending memory request; flags the cycle that would exhaust the budget.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt_q <= '0;
    else if (inc)     cnt_q <= cnt_q + W'(1);
  end

  // Looks one count ahead so the trap follows exactly LIMIT unanswered cycles.
  assign expire = inc && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one handshaked
// memory port, with retired-instruction counter and sticky trap.
module mc_ctrl_fsm
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 illegal,
  input  logic                 branch_taken,
  mc_ctrl_fsm_if.master        mem,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state_q, state_d;
  trap_cause_t           cause_q, cause_d;
  logic [INSTRET_W-1:0]  instret_q;
  logic                  retire;
  logic                  req_active;
  logic                  wait_inc;
  logic                  expire;
  alu_ops_t              ops;

  assign req_active = !rst && (state_q == S_FETCH || state_q == S_MEM);
  assign wait_inc   = req_active && !mem.mem_ready;
  assign ops        = alu_ops(opcode);

  mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wait_inc),
    .inc    (wait_inc),
    .expire (expire)
  );

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so rst is just the first branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= TC_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    retire           = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    mdr_we           = 1'b0;
    pc_we            = 1'b0;
    pc_src           = PC_PLUS4;
    reg_we           = 1'b0;
    wb_sel           = WB_ALU;
    alu_a_sel        = A_RS1;
    alu_b_sel        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel = ops.a_sel;
        alu_b_sel = ops.b_sel;
        case (opcode)
          OP, OP_IMM, AUIPC, JAL, JALR: state_d = S_WB;
          LUI: begin
            wb_sel  = WB_IMM;
            state_d = S_WB;
          end
          LOAD, STORE: state_d = S_MEM;
          BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? PC_IMM : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          MISC_MEM: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          SYSTEM: begin
            state_d = S_TRAP;
            cause_d = TC_SYSTEM;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        alu_a_sel        = ops.a_sel;
        alu_b_sel        = ops.b_sel;
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (opcode == STORE);
        if (mem.mem_ready) begin
          if (opcode == STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end
      end
      S_WB: begin
        alu_a_sel = ops.a_sel;
        alu_b_sel = ops.b_sel;
        reg_we    = 1'b1;
        wb_sel    = wb_sel_for(opcode);
        pc_we     = 1'b1;
        pc_src    = wb_pc_src(opcode);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: ;
      default: begin
        state_d = S_TRAP;
        cause_d = TC_ILLEGAL;
      end
    endcase

    // A reset cycle abandons the instruction: nothing may write or update the pc.
    if (rst) begin
      retire           = 1'b0;
      mem.mem_req      = 1'b0;
      mem.mem_we       = 1'b0;
      mem.mem_addr_sel = 1'b0;
      ir_we            = 1'b0;
      mdr_we           = 1'b0;
      pc_we            = 1'b0;
      pc_src           = PC_PLUS4;
      reg_we           = 1'b0;
      wb_sel           = WB_ALU;
      alu_a_sel        = A_RS1;
      alu_b_sel        = 1'b0;
    end
  end

  assign mem.mem_size = funct3;
  assign state        = state_q;
  assign trap         = (state_q == S_TRAP);
  assign trap_cause   = cause_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench: each instruction is expanded into a cycle-by-cycle
// expectation plan from the sequencing rules, then driven and compared.
module tb_mc_ctrl_fsm;
  import rv32_ctrl_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          illegal;
  logic          branch_taken;
  logic          ir_we, mdr_we, pc_we, reg_we, alu_b_sel, trap;
  logic [1:0]    pc_src, wb_sel, alu_a_sel, trap_cause;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  mc_ctrl_fsm_if mem_if ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .illegal      (illegal),
    .branch_taken (branch_taken),
    .mem          (mem_if),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .state        (state),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One expected cycle; the chk_* flags mark selects that matter in that cycle.
  typedef struct packed {
    logic       ready;
    logic [2:0] st;
    logic       req, we, asel, ir, mdr, pcwe;
    logic [1:0] pcs;
    logic       rwe;
    logic [1:0] wbs;
    logic       chk_a, chk_b, chk_wb;
    logic [1:0] asl;
    logic       bsl;
    logic       retire;
  } cyc_t;

  cyc_t        plan[$];
  logic [31:0] m_instret;
  logic        end_trap;
  logic [1:0]  end_cause;

  logic [6:0] legal_ops [10] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM};

  function automatic cyc_t idle(input logic [2:0] st);
    cyc_t c;
    c       = '0;
    c.st    = st;
    c.ready = 1'($urandom);
    return c;
  endfunction

  function automatic logic [31:0] exp_vec(input cyc_t c);
    return {11'd0, funct3, c.req, c.we, c.asel, c.ir, c.mdr, c.pcwe,
            c.pcwe ? c.pcs : 2'b00, c.rwe, (c.rwe || c.chk_wb) ? c.wbs : 2'b00,
            c.chk_a ? c.asl : 2'b00, c.chk_b ? c.bsl : 1'b0, c.st, 1'b0};
  endfunction

  function automatic logic [31:0] act_vec(input cyc_t c);
    return {11'd0, mem_if.mem_size, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel,
            ir_we, mdr_we, pc_we, c.pcwe ? pc_src : 2'b00, reg_we,
            (c.rwe || c.chk_wb) ? wb_sel : 2'b00, c.chk_a ? alu_a_sel : 2'b00,
            c.chk_b ? alu_b_sel : 1'b0, state, trap};
  endfunction

  // Expands one instruction into its expected cycles; fw/mw = cycles before mem_ready.
  task automatic build(input logic [6:0] opc, input int fw, input int mw,
                       input logic tk, input logic ill);
    cyc_t c;
    plan.delete();
    end_trap  = 1'b0;
    end_cause = 2'b00;
    for (int i = 0; i <= fw && i < int'(TO); i++) begin
      c = idle(3'd0); c.req = 1'b1; c.ready = (i == fw); c.ir = (i == fw);
      plan.push_back(c);
    end
    if (fw >= int'(TO)) begin end_trap = 1'b1; end_cause = 2'b11; return; end
    plan.push_back(idle(3'd1));
    if (ill) begin end_trap = 1'b1; end_cause = 2'b01; return; end
    c = idle(3'd2);
    case (opc)
      OP:                  begin c.chk_b = 1'b1; c.bsl = 1'b0; end
      OP_IMM, LOAD, STORE: begin c.chk_b = 1'b1; c.bsl = 1'b1; end
      AUIPC:               begin c.chk_a = 1'b1; c.chk_b = 1'b1; c.asl = 2'b01; c.bsl = 1'b1; end
      JAL, JALR:           begin c.chk_a = 1'b1; c.chk_b = 1'b1; c.asl = 2'b00; c.bsl = 1'b1; end
      LUI:                 begin c.chk_wb = 1'b1; c.wbs = 2'b11; end
      BRANCH: begin
        c.chk_a = 1'b1; c.chk_b = 1'b1;
        c.pcwe = 1'b1; c.pcs = tk ? 2'b01 : 2'b00; c.retire = 1'b1;
      end
      MISC_MEM: begin c.pcwe = 1'b1; c.pcs = 2'b00; c.retire = 1'b1; end
      default: ;
    endcase
    plan.push_back(c);
    if (opc == SYSTEM) begin end_trap = 1'b1; end_cause = 2'b10; return; end
    if (opc == BRANCH || opc == MISC_MEM) return;
    if (opc == LOAD || opc == STORE) begin
      for (int i = 0; i <= mw && i < int'(TO); i++) begin
        c = idle(3'd3); c.req = 1'b1; c.asel = 1'b1; c.we = (opc == STORE);
        c.ready = (i == mw);
        if (i == mw) begin
          if (opc == STORE) begin c.pcwe = 1'b1; c.retire = 1'b1; end
          else c.mdr = 1'b1;
        end
        plan.push_back(c);
      end
      if (mw >= int'(TO)) begin end_trap = 1'b1; end_cause = 2'b11; return; end
      if (opc == STORE) return;
    end
    c = idle(3'd4); c.rwe = 1'b1; c.pcwe = 1'b1; c.retire = 1'b1;
    c.wbs = (opc == LOAD) ? 2'b01 : (opc == JAL || opc == JALR) ? 2'b10 :
            (opc == LUI) ? 2'b11 : 2'b00;
    c.pcs = (opc == JAL) ? 2'b01 : (opc == JALR) ? 2'b10 : 2'b00;
    plan.push_back(c);
  endtask

  task automatic run_plan(input string tag);
    foreach (plan[i]) begin
      mem_if.mem_ready = plan[i].ready;
      @(negedge clk);
      check({tag, "/out"}, act_vec(plan[i]), exp_vec(plan[i]));
      check({tag, "/instret"}, instret, m_instret);
      if (plan[i].retire) m_instret = m_instret + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input logic [6:0] opc, input int fw, input int mw,
                          input logic tk, input logic ill, input string tag);
    opcode       = opc;
    illegal      = ill;
    branch_taken = tk;
    funct3       = 3'($urandom);
    build(opc, fw, mw, tk, ill);
    run_plan(tag);
    mem_if.mem_ready = 1'($urandom);
    check({tag, "/end_state"}, {29'd0, state}, end_trap ? 32'd5 : 32'd0);
    check({tag, "/end_trap"}, {30'd0, trap, trap_cause}, {30'd0, end_trap, end_cause});
    check({tag, "/end_instret"}, instret, m_instret);
  endtask

  task automatic hold_trap(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      mem_if.mem_ready = 1'($urandom);
      opcode           = legal_ops[$urandom_range(0, 9)];
      @(negedge clk);
      check({tag, "/hold"},
            {3'd0, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, ir_we, mdr_we, pc_we,
             reg_we, state, trap, trap_cause, instret[15:0]},
            {3'd0, 7'd0, 3'd5, 1'b1, end_cause, m_instret[15:0]});
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mem_if.mem_ready = 1'($urandom);
    @(posedge clk); #1;
    m_instret = 0;
    check({tag, "/rst_state"}, {26'd0, trap, trap_cause, state}, 32'd0);
    check({tag, "/rst_instret"}, instret, 32'd0);
    check({tag, "/rst_en"},
          {25'd0, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, ir_we, mdr_we, pc_we, reg_we},
          32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = OP; funct3 = 3'd0; illegal = 1'b0; branch_taken = 1'b0;
    mem_if.mem_ready = 1'b0;
    m_instret = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    do_instr(OP, 0, 0, 1'b0, 1'b0, "add");
    do_instr(LOAD, 0, 3, 1'b0, 1'b0, "lw_wait3");
    do_instr(BRANCH, 0, 0, 1'b1, 1'b0, "beq_taken");
    do_instr(BRANCH, 1, 0, 1'b0, 1'b0, "beq_not");
    do_instr(OP, int'(TO) - 1, 0, 1'b0, 1'b0, "fetch_late");
    do_instr(OP, int'(TO), 0, 1'b0, 1'b0, "fetch_to");
    hold_trap(5, "fetch_to");
    do_reset("fetch_to");

    do_instr(STORE, 0, int'(TO), 1'b0, 1'b0, "mem_to");
    hold_trap(3, "mem_to");
    do_reset("mem_to");

    do_instr(7'h7F, 0, 0, 1'b0, 1'b1, "illegal");
    hold_trap(20, "illegal");
    do_reset("illegal");

    do_instr(SYSTEM, 0, 0, 1'b0, 1'b0, "ecall");
    do_reset("ecall");

    // Reset lands while a store is still waiting on the memory port.
    opcode = STORE; illegal = 1'b0; funct3 = 3'd2;
    build(STORE, 0, int'(TO), 1'b0, 1'b0);
    while (plan.size() > 4) void'(plan.pop_back());
    run_plan("sw_rst");
    mem_if.mem_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("sw_rst/abandon", {29'd0, mem_if.mem_req, mem_if.mem_we, pc_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_instret = 0;
    check("sw_rst/state", {29'd0, state}, 32'd0);
    check("sw_rst/instret", instret, 32'd0);
    do_instr(JAL, 0, 0, 1'b0, 1'b0, "after_rst");

    for (int n = 0; n < 80; n++) begin
      logic [6:0] opc;
      int         r, fw, mw;
      logic       ill;
      r   = int'($urandom_range(0, 19));
      opc = legal_ops[$urandom_range(0, 9)];
      fw  = int'($urandom_range(0, TO - 1));
      mw  = int'($urandom_range(0, TO - 1));
      ill = 1'b0;
      if (r == 0) ill = 1'b1;
      else if (r == 1) opc = SYSTEM;
      else if (r == 2) fw = int'(TO);
      else if (r == 3) begin opc = LOAD; mw = int'(TO); end
      do_instr(opc, fw, mw, 1'($urandom), ill, "rand");
      if (end_trap) begin
        hold_trap(3, "rand");
        do_reset("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
